// File: rtl/regfile_arb_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: width defaults, the discarded zero-register index, requester ids
// and the {addr, data} write-request struct used at default widths.
package regfile_arb_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 64;
  localparam int unsigned ADDR_WIDTH_DEF = 5;
  localparam int unsigned ZERO_REG_DEF   = 31;
  localparam int unsigned CNT_WIDTH_DEF  = 8;

  // Requester ids double as the round-robin priority encoding.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [DATA_WIDTH_DEF-1:0] data;
  } wr_req_t;

  // The requester that gets priority after `id` has been served.
  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ_ALU) ? REQ_MEM : REQ_ALU;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-input round-robin arbiter with a one-bit priority pointer.
// Latency: grant is combinational in the request cycle; pointer updates at the edge.
// Backpressure: stall suppresses every grant and freezes the pointer.
//
// Ports:
//   clk, reset_n      clock, async active-low reset (grants forced low in reset)
//   valid[1:0]  in    per-requester request
//   stall       in    downstream cannot accept; no grant this cycle
//   grant[1:0]  out   one-hot (or zero) grant
module rr_arbiter_2
  import regfile_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] valid,
  input  logic       stall,
  output logic [1:0] grant
);

  req_id_e prio_q;
  req_id_e prio_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_q <= REQ_ALU;
    end else begin
      prio_q <= prio_d;
    end
  end

  // Grant is gated by reset_n so readies read 0 while reset is held, even
  // though the pointer flop alone would already be in a defined state.
  always_comb begin
    grant  = 2'b00;
    prio_d = prio_q;
    if (reset_n && !stall) begin
      unique case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (prio_q == REQ_MEM) ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
    if (grant[0]) begin
      prio_d = other_req(REQ_ALU);
    end else if (grant[1]) begin
      prio_d = other_req(REQ_MEM);
    end
  end

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (!reset_n)
    !(grant[0] && grant[1]));

  a_grant_needs_valid : assert property (@(posedge clk) disable iff (!reset_n)
    (grant & ~valid) == 2'b00);

  a_stall_no_grant : assert property (@(posedge clk) disable iff (!reset_n)
    stall |-> (grant == 2'b00));

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU and load writeback onto the register file's single write port.
// Latency: 1 cycle from handshake to wr_en; one write per cycle when not stalled.
// Backpressure: wr_stall withholds all readies; requesters hold until ready.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   reqN_valid/addr/data  in     writeback request from requester N (0=ALU, 1=MEM)
//   reqN_ready            out    same-cycle accept for requester N
//   wr_stall              in     register file busy; no grants this cycle
//   wr_en/addr/data/src   out    registered write port toward the register file
//   contention_cnt        out    saturating count of cycles with an unserved request
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned ZERO_REG   = ZERO_REG_DEF,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,

  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,

  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,

  input  logic                  wr_stall,

  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_src,

  output logic [CNT_WIDTH-1:0]  contention_cnt
);

  // Parameterized mirror of the package write-request struct.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

  logic [1:0] grant;
  logic       gnt_any;
  req_id_e    gnt_id;
  req_t       req0;
  req_t       req1;
  req_t       sel;

  logic                  wr_en_q,   wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  req_id_e               wr_src_q,  wr_src_d;
  logic [CNT_WIDTH-1:0]  cnt_q,     cnt_d;
  logic                  contended;

  assign req0 = '{addr: req0_addr, data: req0_data};
  assign req1 = '{addr: req1_addr, data: req1_data};

  rr_arbiter_2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .valid   ({req1_valid, req0_valid}),
    .stall   (wr_stall),
    .grant   (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  assign gnt_any = grant[0] | grant[1];
  assign gnt_id  = grant[1] ? REQ_MEM : REQ_ALU;
  assign sel     = grant[1] ? req1 : req0;

  // A zero-register write still consumes a grant (handshake, pointer move) and
  // updates the address/data/src fields; only the enable is suppressed.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_src_d  = wr_src_q;
    if (gnt_any) begin
      wr_en_d   = (sel.addr != ZERO_ADDR);
      wr_addr_d = sel.addr;
      wr_data_d = sel.data;
      wr_src_d  = gnt_id;
    end
  end

  // One increment per cycle at most, however many requesters were left waiting.
  assign contended = (req0_valid & ~grant[0]) | (req1_valid & ~grant[1]);

  always_comb begin
    cnt_d = cnt_q;
    if (contended && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_src_q  <= REQ_ALU;
      cnt_q     <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_src_q  <= wr_src_d;
      cnt_q     <= cnt_d;
    end
  end

  assign wr_en          = wr_en_q;
  assign wr_addr        = wr_addr_q;
  assign wr_data        = wr_data_q;
  assign wr_src         = wr_src_q;
  assign contention_cnt = cnt_q;

  a_no_zero_write : assert property (@(posedge clk) disable iff (!reset_n)
    wr_en |-> (wr_addr != ZERO_ADDR));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with hand-computed expectations.
// Latency: inputs driven 1ns after the rising edge, outputs sampled before the next.
// Backpressure: exercised through wr_stall and two-requester contention.
module tb_regfile_write_arbiter;
  import regfile_arb_pkg::*;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int CW = 8;

  logic          clk;
  logic          reset_n;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_addr,  req1_addr;
  logic [DW-1:0] req0_data,  req1_data;
  logic          req0_ready, req1_ready;
  logic          wr_stall;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_src;
  logic [CW-1:0] contention_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  regfile_write_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .ZERO_REG   (31),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req0_valid     (req0_valid),
    .req0_addr      (req0_addr),
    .req0_data      (req0_data),
    .req0_ready     (req0_ready),
    .req1_valid     (req1_valid),
    .req1_addr      (req1_addr),
    .req1_data      (req1_data),
    .req1_ready     (req1_ready),
    .wr_stall       (wr_stall),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_src         (wr_src),
    .contention_cnt (contention_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input wr_req_t r);
    req0_valid = v;
    req0_addr  = r.addr;
    req0_data  = r.data;
  endtask

  task automatic drive1(input logic v, input wr_req_t r);
    req1_valid = v;
    req1_addr  = r.addr;
    req1_data  = r.data;
  endtask

  task automatic check_wr(input string tag, input logic en, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic s);
    check({tag, ".wr_en"},   64'(wr_en),   64'(en));
    check({tag, ".wr_addr"}, 64'(wr_addr), 64'(a));
    check({tag, ".wr_data"}, wr_data,      d);
    check({tag, ".wr_src"},  64'(wr_src),  64'(s));
  endtask

  wr_req_t ra, rb;

  initial begin
    reset_n  = 1'b0;
    wr_stall = 1'b0;
    ra = '{addr: 5'd1, data: 64'hA1};
    rb = '{addr: 5'd2, data: 64'hB2};
    drive0(1'b1, ra);
    drive1(1'b1, rb);

    // Reset held with both requesters valid.
    repeat (3) tick();
    check("rst.ready0", 64'(req0_ready), 64'd0);
    check("rst.ready1", 64'(req1_ready), 64'd0);
    check_wr("rst", 1'b0, 5'd0, 64'd0, 1'b0);
    check("rst.cnt", 64'(contention_cnt), 64'd0);

    // Release: alternating grants 0,1,0,1 starting with requester 0.
    reset_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("alt%0d.ready0", i), 64'(req0_ready), 64'(i % 2 == 0));
      check($sformatf("alt%0d.ready1", i), 64'(req1_ready), 64'(i % 2 == 1));
      tick();
      if (i % 2 == 0) check_wr($sformatf("alt%0d", i), 1'b1, 5'd1, 64'hA1, 1'b0);
      else            check_wr($sformatf("alt%0d", i), 1'b1, 5'd2, 64'hB2, 1'b1);
    end
    check("alt.cnt", 64'(contention_cnt), 64'd4);

    // Idle cycle: no write, fields hold.
    drive0(1'b0, ra);
    drive1(1'b0, rb);
    tick();
    check_wr("idle", 1'b0, 5'd2, 64'hB2, 1'b1);

    // Single requester 0 write.
    drive0(1'b1, '{addr: 5'd5, data: 64'hDEAD});
    #1;
    check("single.ready0", 64'(req0_ready), 64'd1);
    check("single.ready1", 64'(req1_ready), 64'd0);
    tick();
    drive0(1'b0, ra);
    check_wr("single", 1'b1, 5'd5, 64'hDEAD, 1'b0);
    tick();
    check_wr("single.after", 1'b0, 5'd5, 64'hDEAD, 1'b0);
    check("single.cnt", 64'(contention_cnt), 64'd4);

    // Zero register from requester 1 (prio currently 1 -> moves to 0).
    drive1(1'b1, '{addr: 5'd31, data: 64'h1234});
    #1;
    check("zero.ready1", 64'(req1_ready), 64'd1);
    tick();
    drive1(1'b0, rb);
    check_wr("zero", 1'b0, 5'd31, 64'h1234, 1'b1);

    // Tie right after: requester 0 must win, proving prio moved to 0.
    drive0(1'b1, '{addr: 5'd3, data: 64'h33});
    drive1(1'b1, '{addr: 5'd4, data: 64'h44});
    #1;
    check("zeroprio.ready0", 64'(req0_ready), 64'd1);
    check("zeroprio.ready1", 64'(req1_ready), 64'd0);
    tick();
    drive0(1'b0, ra);
    drive1(1'b0, rb);
    check_wr("zeroprio", 1'b1, 5'd3, 64'h33, 1'b0);
    check("zeroprio.cnt", 64'(contention_cnt), 64'd5);

    // Stall 3 cycles with requester 0 valid.
    wr_stall = 1'b1;
    drive0(1'b1, '{addr: 5'd7, data: 64'h77});
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("stall%0d.ready0", i), 64'(req0_ready), 64'd0);
      tick();
      check($sformatf("stall%0d.wr_en", i), 64'(wr_en), 64'd0);
    end
    check("stall.cnt", 64'(contention_cnt), 64'd8);
    wr_stall = 1'b0;
    #1;
    check("unstall.ready0", 64'(req0_ready), 64'd1);
    tick();
    drive0(1'b0, ra);
    check_wr("unstall", 1'b1, 5'd7, 64'h77, 1'b0);
    check("unstall.cnt", 64'(contention_cnt), 64'd8);

    // Stall with both valid: no readies, prio (1) held, +1.
    wr_stall = 1'b1;
    drive0(1'b1, '{addr: 5'd8, data: 64'h88});
    drive1(1'b1, '{addr: 5'd9, data: 64'h99});
    #1;
    check("stall2.ready0", 64'(req0_ready), 64'd0);
    check("stall2.ready1", 64'(req1_ready), 64'd0);
    tick();
    check("stall2.cnt", 64'(contention_cnt), 64'd9);
    wr_stall = 1'b0;
    #1;
    check("stall2.held_prio", 64'(req1_ready), 64'd1);
    tick();
    drive0(1'b0, ra);
    drive1(1'b0, rb);
    check_wr("stall2", 1'b1, 5'd9, 64'h99, 1'b1);
    check("stall2.cnt_after", 64'(contention_cnt), 64'd10);

    // Saturation: 300 stalled cycles with requester 0 waiting.
    wr_stall = 1'b1;
    drive0(1'b1, '{addr: 5'd12, data: 64'hC});
    repeat (244) tick();
    check("sat.254", 64'(contention_cnt), 64'd254);
    tick();
    check("sat.255", 64'(contention_cnt), 64'd255);
    repeat (55) tick();
    check("sat.hold", 64'(contention_cnt), 64'd255);

    // Grant, then reset the cycle after: registered write is dropped at once.
    wr_stall = 1'b0;
    #1;
    check("mid.ready0", 64'(req0_ready), 64'd1);
    tick();
    drive0(1'b0, ra);
    check_wr("mid", 1'b1, 5'd12, 64'hC, 1'b0);
    reset_n = 1'b0;
    #1;
    check_wr("midrst", 1'b0, 5'd0, 64'd0, 1'b0);
    check("midrst.cnt", 64'(contention_cnt), 64'd0);
    drive1(1'b1, rb);
    #1;
    check("midrst.ready1", 64'(req1_ready), 64'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
